// File: rtl/crc32_frame_checker.sv
// Receive-side serial CRC32 checker: runs the MSB-first LFSR over payload and FCS,
// then reports pass / CRC error / length error one cycle after the last FCS bit.
module crc32_frame_checker #(
  parameter logic [31:0] INIT             = 32'hFFFF_FFFF,
  parameter logic [31:0] RESIDUE          = 32'h0000_0000,
  parameter int          MIN_PAYLOAD_BITS = 8,
  parameter int          CNT_W            = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BIT_IN,
  input  logic             BIT_VALID,
  input  logic             FRAME_START,
  input  logic             FRAME_END,
  output logic             BUSY,
  output logic             DONE,
  output logic             CRC_OK,
  output logic             CRC_ERR,
  output logic             LEN_ERR,
  output logic [31:0]      CRC_VALUE,
  output logic [31:0]      RX_FCS,
  output logic [CNT_W-1:0] BIT_COUNT
);

  localparam logic [31:0]      POLY    = 32'h04C1_1DB7;
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(32 + MIN_PAYLOAD_BITS);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RECV, REPORT} state_t;

  state_t           r_state;
  logic [31:0]      r_crc;
  logic [31:0]      r_rx_fcs;
  logic [CNT_W-1:0] r_cnt;
  logic             r_done;
  logic             r_ok;
  logic             r_crc_err;
  logic             r_len_err;

  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_crc_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_len_err;
  logic             w_crc_err;

  function automatic logic [31:0] lfsr_step(input logic [31:0] r, input logic b);
    logic fb;
    fb = r[31] ^ b;
    return {r[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
  endfunction

  // A start beat restarts from INIT whether idle or mid-frame; REPORT ignores all input.
  assign w_start    = BIT_VALID & FRAME_START & (r_state != REPORT);
  assign w_accept   = w_start | (BIT_VALID & (r_state == RECV));
  assign w_last     = w_accept & FRAME_END;
  assign w_crc_next = lfsr_step(w_start ? INIT : r_crc, BIT_IN);
  assign w_cnt_next = w_start ? CNT_ONE :
                      (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;

  assign w_len_err  = (w_cnt_next < MIN_LEN) | (w_cnt_next[2:0] != 3'b000) |
                      (w_cnt_next == CNT_MAX);
  assign w_crc_err  = !w_len_err & (w_crc_next != RESIDUE);

  // The INIT load is folded into the first step, so the register can reset to zero.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_crc     <= '0;
      r_rx_fcs  <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_ok      <= 1'b0;
      r_crc_err <= 1'b0;
      r_len_err <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_crc    <= w_crc_next;
        r_rx_fcs <= w_start ? {31'b0, BIT_IN} : {r_rx_fcs[30:0], BIT_IN};
        r_cnt    <= w_cnt_next;
      end
      if (w_start) begin
        r_ok      <= 1'b0;
        r_crc_err <= 1'b0;
        r_len_err <= 1'b0;
      end
      if (w_last) begin
        r_done    <= 1'b1;
        r_len_err <= w_len_err;
        r_crc_err <= w_crc_err;
        r_ok      <= !w_len_err & !w_crc_err;
      end
      case (r_state)
        IDLE:    if (w_start) r_state <= FRAME_END ? REPORT : RECV;
        RECV:    if (w_last) r_state <= REPORT;
        REPORT:  r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign BUSY      = (r_state == RECV);
  assign DONE      = r_done;
  assign CRC_OK    = r_ok;
  assign CRC_ERR   = r_crc_err;
  assign LEN_ERR   = r_len_err;
  assign CRC_VALUE = r_crc;
  assign RX_FCS    = r_rx_fcs;
  assign BIT_COUNT = r_cnt;

endmodule

// File: tb/tb_crc32_frame_checker.sv
// Scoreboard bench for crc32_frame_checker: expectations are queued as frames are driven
// and checked when DONE appears; each scenario task also checks its own specifics.
module tb_crc32_frame_checker;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic        CLK = 1'b0;
  logic        RST, BIT_IN, BIT_VALID, FRAME_START, FRAME_END;
  logic        BUSY, DONE, CRC_OK, CRC_ERR, LEN_ERR;
  logic [31:0] CRC_VALUE, RX_FCS;
  logic [15:0] BIT_COUNT;

  typedef struct {
    logic [31:0] crc;
    logic [31:0] fcs;
    logic [15:0] cnt;
    logic        ok;
    logic        cerr;
    logic        lerr;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_done  = 0;

  always #5 CLK = ~CLK;

  crc32_frame_checker #(
    .INIT(32'h0), .RESIDUE(32'h0), .MIN_PAYLOAD_BITS(8), .CNT_W(16)
  ) dut (
    .CLK(CLK), .RST(RST), .BIT_IN(BIT_IN), .BIT_VALID(BIT_VALID),
    .FRAME_START(FRAME_START), .FRAME_END(FRAME_END), .BUSY(BUSY), .DONE(DONE),
    .CRC_OK(CRC_OK), .CRC_ERR(CRC_ERR), .LEN_ERR(LEN_ERR), .CRC_VALUE(CRC_VALUE),
    .RX_FCS(RX_FCS), .BIT_COUNT(BIT_COUNT)
  );

  function automatic exp_t model(input logic [63:0] f, input int len);
    exp_t e;
    logic fb;
    e.crc = 32'h0;
    e.fcs = 32'h0;
    for (int i = len - 1; i >= 0; i--) begin
      fb    = e.crc[31] ^ f[i];
      e.crc = {e.crc[30:0], 1'b0} ^ (fb ? POLY : 32'h0);
      e.fcs = {e.fcs[30:0], f[i]};
    end
    e.cnt  = 16'(len);
    e.lerr = (len < 40) || (len % 8 != 0);
    e.cerr = !e.lerr && (e.crc != 32'h0);
    e.ok   = !e.lerr && (e.crc == 32'h0);
    return e;
  endfunction

  // Scoreboard: pop one expectation per DONE pulse.
  always @(negedge CLK) begin
    exp_t e;
    if (DONE === 1'b1) begin
      n_done++;
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done: DONE=1 got, no frame outstanding required");
      end else begin
        e = sb.pop_front();
        if ({CRC_OK, CRC_ERR, LEN_ERR} !== {e.ok, e.cerr, e.lerr}) begin
          n_fail++;
          $display("FAIL sb_flags: ok/cerr/lerr got %b%b%b required %b%b%b",
                   CRC_OK, CRC_ERR, LEN_ERR, e.ok, e.cerr, e.lerr);
        end
        n_tests++;
        if ({CRC_VALUE, RX_FCS, BIT_COUNT} !== {e.crc, e.fcs, e.cnt}) begin
          n_fail++;
          $display("FAIL sb_values: crc/fcs/cnt got %h/%h/%0d required %h/%h/%0d",
                   CRC_VALUE, RX_FCS, BIT_COUNT, e.crc, e.fcs, e.cnt);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required to finish");
    $fatal(1);
  end

  task automatic drive_frame(input logic [63:0] f, input int len, input bit toggle,
                             input bit send_end, output int busy_low,
                             output logic [2:0] flags_start);
    busy_low    = 0;
    flags_start = 3'bxxx;
    for (int i = len - 1; i >= 0; i--) begin
      BIT_IN      = f[i];
      BIT_VALID   = 1'b1;
      FRAME_START = (i == len - 1);
      FRAME_END   = send_end && (i == 0);
      if (send_end && i == 0) sb.push_back(model(f, len));
      @(posedge CLK); #1;
      if (i == len - 1) flags_start = {CRC_OK, CRC_ERR, LEN_ERR};
      if ((i != 0 || !send_end) && BUSY !== 1'b1) busy_low++;
      if (toggle && i != 0) begin
        BIT_VALID   = 1'b0;
        FRAME_START = 1'b1;
        FRAME_END   = 1'b1;
        BIT_IN      = 1'($urandom);
        @(posedge CLK); #1;
        if (BUSY !== 1'b1) busy_low++;
      end
    end
    BIT_VALID   = 1'b0;
    FRAME_START = 1'b0;
    FRAME_END   = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; BIT_IN = 1'b0; BIT_VALID = 1'b0; FRAME_START = 1'b0; FRAME_END = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if ({BUSY, DONE, CRC_OK, CRC_ERR, LEN_ERR, CRC_VALUE, RX_FCS, BIT_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b flags=%b%b%b crc=%h fcs=%h cnt=%0d required all 0",
               BUSY, DONE, CRC_OK, CRC_ERR, LEN_ERR, CRC_VALUE, RX_FCS, BIT_COUNT);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_zero_frame();
    int bl; logic [2:0] fs;
    drive_frame({24'h0, 8'h00, 32'h0000_0000}, 40, 1'b0, 1'b1, bl, fs);
    n_tests++;
    if (DONE !== 1'b1 || CRC_OK !== 1'b1 || CRC_VALUE !== 32'h0 || BIT_COUNT !== 16'd40) begin
      n_fail++;
      $display("FAIL zero_frame: done=%b ok=%b crc=%h cnt=%0d required 1 1 00000000 40",
               DONE, CRC_OK, CRC_VALUE, BIT_COUNT);
    end
    @(posedge CLK); #1;
    n_tests++;
    if (DONE !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: DONE got %b required 0", DONE);
    end
  endtask

  task automatic test_good_bad();
    int bl; logic [2:0] fs;
    drive_frame({24'h0, 8'h80, 32'h690C_E0EE}, 40, 1'b0, 1'b1, bl, fs);
    n_tests++;
    if (DONE !== 1'b1 || CRC_OK !== 1'b1 || RX_FCS !== 32'h690C_E0EE || CRC_VALUE !== 32'h0) begin
      n_fail++;
      $display("FAIL good_frame: done=%b ok=%b fcs=%h crc=%h required 1 1 690ce0ee 00000000",
               DONE, CRC_OK, RX_FCS, CRC_VALUE);
    end
    @(posedge CLK); #1;
    drive_frame({24'h0, 8'h80, 32'h690C_E0EF}, 40, 1'b0, 1'b1, bl, fs);
    n_tests++;
    if (DONE !== 1'b1 || CRC_ERR !== 1'b1 || CRC_OK !== 1'b0 || CRC_VALUE === 32'h0) begin
      n_fail++;
      $display("FAIL bad_frame: done=%b err=%b ok=%b crc=%h required 1 1 0 nonzero",
               DONE, CRC_ERR, CRC_OK, CRC_VALUE);
    end
    // A start beat during the report cycle must be ignored.
    BIT_VALID = 1'b1; FRAME_START = 1'b1; BIT_IN = 1'b1;
    @(posedge CLK); #1;
    BIT_VALID = 1'b0; FRAME_START = 1'b0;
    n_tests++;
    if (BUSY !== 1'b0 || BIT_COUNT !== 16'd40 || CRC_ERR !== 1'b1) begin
      n_fail++;
      $display("FAIL report_ignores_start: busy=%b cnt=%0d err=%b required 0 40 1",
               BUSY, BIT_COUNT, CRC_ERR);
    end
  endtask

  task automatic test_toggle_valid();
    int bl; logic [2:0] fs;
    drive_frame({24'h0, 8'h80, 32'h690C_E0EE}, 40, 1'b1, 1'b1, bl, fs);
    n_tests++;
    if (DONE !== 1'b1 || CRC_OK !== 1'b1 || CRC_VALUE !== 32'h0 || BIT_COUNT !== 16'd40) begin
      n_fail++;
      $display("FAIL toggle_result: done=%b ok=%b crc=%h cnt=%0d required 1 1 00000000 40",
               DONE, CRC_OK, CRC_VALUE, BIT_COUNT);
    end
    n_tests++;
    if (bl != 0) begin
      n_fail++;
      $display("FAIL toggle_busy: BUSY low in %0d frame cycles, required 0", bl);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_len_err();
    int bl; logic [2:0] fs;
    drive_frame(64'h0000_0000_0000_A5C3, 16, 1'b0, 1'b1, bl, fs);
    n_tests++;
    if ({CRC_OK, CRC_ERR, LEN_ERR} !== 3'b001 || BIT_COUNT !== 16'd16) begin
      n_fail++;
      $display("FAIL len16: flags=%b%b%b cnt=%0d required 001 16", CRC_OK, CRC_ERR, LEN_ERR, BIT_COUNT);
    end
    @(posedge CLK); #1;
    drive_frame({23'h0, 1'b1, 8'h80, 32'h690C_E0EE}, 41, 1'b0, 1'b1, bl, fs);
    n_tests++;
    if (LEN_ERR !== 1'b1 || BIT_COUNT !== 16'd41) begin
      n_fail++;
      $display("FAIL len41: len_err=%b cnt=%0d required 1 41", LEN_ERR, BIT_COUNT);
    end
    @(posedge CLK); #1;
    drive_frame(64'h1, 1, 1'b0, 1'b1, bl, fs);
    n_tests++;
    if (DONE !== 1'b1 || LEN_ERR !== 1'b1 || BIT_COUNT !== 16'd1) begin
      n_fail++;
      $display("FAIL len1: done=%b len_err=%b cnt=%0d required 1 1 1", DONE, LEN_ERR, BIT_COUNT);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_abort_restart();
    int bl; logic [2:0] fs; int d0;
    d0 = n_done;
    drive_frame(64'h0000_0000_000F_3A5C, 20, 1'b0, 1'b0, bl, fs);
    drive_frame({24'h0, 8'h80, 32'h690C_E0EE}, 40, 1'b0, 1'b1, bl, fs);
    @(negedge CLK); #1;
    n_tests++;
    if (n_done - d0 != 1 || CRC_OK !== 1'b1 || BIT_COUNT !== 16'd40) begin
      n_fail++;
      $display("FAIL restart: dones=%0d ok=%b cnt=%0d required 1 1 40", n_done - d0, CRC_OK, BIT_COUNT);
    end
    @(posedge CLK); #1;
    d0 = n_done;
    drive_frame(64'h0000_0000_000A_BCDE, 20, 1'b0, 1'b0, bl, fs);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    n_tests++;
    if ({BUSY, DONE, CRC_OK, CRC_ERR, LEN_ERR, CRC_VALUE, RX_FCS, BIT_COUNT} !== '0) begin
      n_fail++;
      $display("FAIL midframe_reset: busy=%b done=%b crc=%h fcs=%h cnt=%0d required all 0",
               BUSY, DONE, CRC_VALUE, RX_FCS, BIT_COUNT);
    end
    repeat (4) @(posedge CLK);
    #1;
    n_tests++;
    if (n_done != d0 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_done: dones=%0d busy=%b required 0 0", n_done - d0, BUSY);
    end
  endtask

  task automatic test_back_to_back();
    int bl; logic [2:0] fs; int d0;
    d0 = n_done;
    drive_frame({24'h0, 8'h80, 32'h690C_E0EE}, 40, 1'b0, 1'b1, bl, fs);
    @(posedge CLK); #1;
    n_tests++;
    if (DONE !== 1'b0 || CRC_OK !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle_hold: done=%b ok=%b busy=%b required 0 1 0", DONE, CRC_OK, BUSY);
    end
    drive_frame({24'h0, 8'h80, 32'h690C_E0EE}, 40, 1'b0, 1'b1, bl, fs);
    n_tests++;
    if (fs !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_flag_clear: flags after start got %b required 000", fs);
    end
    n_tests++;
    if (DONE !== 1'b1 || CRC_OK !== 1'b1 || bl != 0) begin
      n_fail++;
      $display("FAIL b2b_second: done=%b ok=%b busy_low=%0d required 1 1 0", DONE, CRC_OK, bl);
    end
    @(negedge CLK); #1;
    n_tests++;
    if (n_done - d0 != 2) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d required 2", n_done - d0);
    end
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_good_bad();
    test_toggle_valid();
    test_len_err();
    test_abort_restart();
    test_back_to_back();
    repeat (3) @(posedge CLK);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: %0d expected results never produced, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
